freq_det_multi: RTL and testbench

Multi-channel successor to the single-channel frequency detector used on the SN76489 verification bench. It measures the period and peak-to-peak magnitude of NUM_CH multi-bit tone/noise sample streams. Each period result is averaged over 2^AVG_LOG2 cycles of the input waveform. Results go out on one shared valid/ready result port through a round-robin arbiter, so the checker can consume all generators from a single stream.

---
 rtl/freq_det_multi_if.sv | 27 ++
 rtl/freq_det_multi.sv | 259 +++++++++++++++++++++++++
 tb/tb_freq_det_multi.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_det_multi_if.sv
// Result stream of freq_det_multi: one shared valid/ready port carrying the
// channel index, averaged period, peak-to-peak magnitude and status flags.
interface freq_det_multi_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                res_valid_o;
  logic                res_ready_i;
  logic [CH_W-1:0]     res_ch_o;
  logic [CNT_W-1:0]    res_period_o;
  logic [SAMPLE_W-1:0] res_mag_o;
  logic                res_timeout_o;
  logic                res_overrun_o;

  modport master (
    output res_valid_o, res_ch_o, res_period_o, res_mag_o, res_timeout_o, res_overrun_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o, res_ch_o, res_period_o, res_mag_o, res_timeout_o, res_overrun_o,
    output res_ready_i
  );
endinterface

// File: rtl/freq_det_multi.sv
// Multi-channel frequency/magnitude detector. Each channel measures the
// period of its sample stream averaged over 2^AVG_LOG2 rising edges, plus
// max-min magnitude over the window, and reports timeouts when no edge is
// seen for TIMEOUT cycles. Results park in a one-deep slot per channel and
// are forwarded through a round-robin arbiter onto one valid/ready port.
// Optional build macro FREQ_DET_HYST_EN: edges only count once the sample
// has climbed HYST LSBs above the trough since the last counted edge.
module freq_det_multi #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 65535,
  parameter int unsigned HYST     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_i,
  input  logic [NUM_CH-1:0]            enable_i,
  output logic [NUM_CH-1:0]            done_o,
  freq_det_multi_if.master             res
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
  localparam int unsigned NP_W  = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NP_W-1:0]  NP_LAST = NP_W'((1 << AVG_LOG2) - 1);

  if (TIMEOUT == 0 || longint'(TIMEOUT) >= (longint'(1) << CNT_W) ||
      longint'(HYST) >= (longint'(1) << SAMPLE_W)) begin : g_param_check
    $error("freq_det_multi: TIMEOUT or HYST out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_MEASURE} state_e;

  // Per-channel result strobes feeding the pending slots
  logic [NUM_CH-1:0]   new_vld;
  logic [NUM_CH-1:0]   new_to;
  logic [CNT_W-1:0]    new_period [NUM_CH];
  logic [SAMPLE_W-1:0] new_mag    [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] smp, prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [NP_W-1:0]     np_q, np_d;
    logic [SAMPLE_W-1:0] min_q, min_d, max_q, max_d, cur_min, cur_max;
    logic                edge_w;
    logic                rv, rto;
    logic [CNT_W-1:0]    rperiod;
    logic [SAMPLE_W-1:0] rmag;

    assign smp = sample_i[c*SAMPLE_W +: SAMPLE_W];

`ifdef FREQ_DET_HYST_EN
    logic [SAMPLE_W-1:0] trough_q, trough_d, thresh;
    logic [SAMPLE_W:0]   thresh_sum;

    assign thresh_sum = {1'b0, trough_q} + (SAMPLE_W+1)'(HYST);
    assign thresh     = thresh_sum[SAMPLE_W] ? '1 : thresh_sum[SAMPLE_W-1:0];
    assign edge_w     = (smp > prev_q) && (smp >= thresh);
    assign trough_d   = edge_w ? smp : ((smp < trough_q) ? smp : trough_q);

    // Trough tracker; all-ones after reset so the first sample seeds it
    always_ff @(posedge clk) begin
      if (rst) trough_q <= '1;
      else     trough_q <= trough_d;
    end
`else
    assign edge_w = smp > prev_q;
`endif

    // Channel FSM: sync to first edge, accumulate periods, emit results
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      np_d    = np_q;
      min_d   = min_q;
      max_d   = max_q;
      rv      = 1'b0;
      rto     = 1'b0;
      rperiod = '0;
      rmag    = '0;
      cur_min = (smp < min_q) ? smp : min_q;
      cur_max = (smp > max_q) ? smp : max_q;
      sum     = acc_q + ACC_W'(cnt_q);
      if (!enable_i[c]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        acc_d   = '0;
        np_d    = '0;
      end else begin
        case (state_q)
          S_IDLE: state_d = S_SYNC;
          S_SYNC: begin
            if (edge_w) begin
              cnt_d   = CNT_W'(1);
              acc_d   = '0;
              np_d    = '0;
              min_d   = smp;
              max_d   = smp;
              state_d = S_MEASURE;
            end else if (cnt_q >= TO_LAST) begin
              rv    = 1'b1;
              rto   = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end
          end
          S_MEASURE: begin
            min_d = cur_min;
            max_d = cur_max;
            if (edge_w) begin
              cnt_d = CNT_W'(1);
              if (np_q == NP_LAST) begin
                rv      = 1'b1;
                rperiod = CNT_W'(sum >> AVG_LOG2);
                rmag    = cur_max - cur_min;
                acc_d   = '0;
                np_d    = '0;
                min_d   = smp;
                max_d   = smp;
              end else begin
                acc_d = sum;
                np_d  = np_q + NP_W'(1);
              end
            end else if (cnt_q >= TO_LAST) begin
              rv      = 1'b1;
              rto     = 1'b1;
              rmag    = cur_max - cur_min;
              cnt_d   = '0;
              state_d = S_SYNC;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        prev_q  <= '0;
        cnt_q   <= '0;
        acc_q   <= '0;
        np_q    <= '0;
        min_q   <= '0;
        max_q   <= '0;
      end else begin
        state_q <= state_d;
        prev_q  <= smp;
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        np_q    <= np_d;
        min_q   <= min_d;
        max_q   <= max_d;
      end
    end

    assign new_vld[c]    = rv;
    assign new_to[c]     = rto;
    assign new_period[c] = rperiod;
    assign new_mag[c]    = rmag;
  end

  // Pending slots, output register and arbiter state
  logic [NUM_CH-1:0]   pend_vld_q, pend_to_q, pend_ovr_q, done_q, take;
  logic [CNT_W-1:0]    pend_period_q [NUM_CH];
  logic [SAMPLE_W-1:0] pend_mag_q    [NUM_CH];
  logic                out_vld_q, out_to_q, out_ovr_q, load, gnt_vld;
  logic [CH_W-1:0]     out_ch_q, rr_ptr_q, gnt_idx;
  logic [CNT_W-1:0]    out_period_q;
  logic [SAMPLE_W-1:0] out_mag_q;

  // Round-robin pick of the first pending slot starting at rr_ptr_q
  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    take    = '0;
    load    = !out_vld_q || res.res_ready_i;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      j = (32'(rr_ptr_q) + i) % NUM_CH;
      if (!gnt_vld && pend_vld_q[CH_W'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(j);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      take[i] = load && gnt_vld && (gnt_idx == CH_W'(i));
    end
  end

  // Slot update: a new result always wins the slot; overrun only flags a
  // result that replaced one which was not leaving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= '0;
      pend_vld_q <= '0;
      pend_to_q  <= '0;
      pend_ovr_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pend_period_q[i] <= '0;
        pend_mag_q[i]    <= '0;
      end
    end else begin
      done_q <= new_vld;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (new_vld[i]) begin
          pend_vld_q[i]    <= 1'b1;
          pend_to_q[i]     <= new_to[i];
          pend_ovr_q[i]    <= pend_vld_q[i] && !take[i];
          pend_period_q[i] <= new_period[i];
          pend_mag_q[i]    <= new_mag[i];
        end else if (take[i]) begin
          pend_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // Output register: reloads whenever empty or accepted, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q    <= 1'b0;
      out_ch_q     <= '0;
      out_period_q <= '0;
      out_mag_q    <= '0;
      out_to_q     <= 1'b0;
      out_ovr_q    <= 1'b0;
      rr_ptr_q     <= '0;
    end else if (load) begin
      out_vld_q <= gnt_vld;
      if (gnt_vld) begin
        out_ch_q     <= gnt_idx;
        out_period_q <= pend_period_q[gnt_idx];
        out_mag_q    <= pend_mag_q[gnt_idx];
        out_to_q     <= pend_to_q[gnt_idx];
        out_ovr_q    <= pend_ovr_q[gnt_idx];
        rr_ptr_q     <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end

  assign done_o            = done_q;
  assign res.res_valid_o   = out_vld_q;
  assign res.res_ch_o      = out_ch_q;
  assign res.res_period_o  = out_period_q;
  assign res.res_mag_o     = out_mag_q;
  assign res.res_timeout_o = out_to_q;
  assign res.res_overrun_o = out_ovr_q;
endmodule

// File: tb/tb_freq_det_multi.sv
// Directed bench for freq_det_multi: square-wave period/magnitude, timeout,
// simultaneous results through the arbiter, back-pressure with overrun, and
// reset in the middle of a measurement window.
module tb_freq_det_multi;
  localparam int NCH = 4;
  localparam int SW  = 8;
  localparam int CW  = 16;
  localparam int TO  = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*SW-1:0] sample = '0;
  logic [NCH-1:0]    enable = '0;
  logic [NCH-1:0]    done;

  freq_det_multi_if #(.NUM_CH(NCH), .SAMPLE_W(SW), .CNT_W(CW)) bus ();

  freq_det_multi #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .CNT_W(CW), .AVG_LOG2(2), .TIMEOUT(TO), .HYST(4)
  ) dut (
    .clk(clk), .rst(rst), .sample_i(sample), .enable_i(enable), .done_o(done), .res(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch; int period; int mag; int to; int ovr; int cyc;
  } rec_t;

  rec_t recs[$];
  int   done0_hits = 0;

  // Record every accepted transfer and count ch0 done pulses
  always @(negedge clk) begin
    if (!rst && bus.res_valid_o && bus.res_ready_i)
      recs.push_back('{ch: int'(bus.res_ch_o), period: int'(bus.res_period_o),
                       mag: int'(bus.res_mag_o), to: int'(bus.res_timeout_o),
                       ovr: int'(bus.res_overrun_o), cyc: cyc});
    if (!rst && done[0]) done0_hits = done0_hits + 1;
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus model: mode 1 = square 0/hi with period 100, else constant
  int mode [NCH];
  int hi   [NCH];
  int cval [NCH];
  int ph = 0;
  int rises[$];
  int base = 0;

  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 100;
    if (ph == 50) rises.push_back(cyc);
    for (int c = 0; c < NCH; c++)
      sample[c*SW +: SW] = (mode[c] == 1) ? ((ph >= 50) ? 8'(hi[c]) : 8'd0) : 8'(cval[c]);
  endtask

  task automatic clear_cfg();
    for (int c = 0; c < NCH; c++) begin
      mode[c] = 0; hi[c] = 0; cval[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = '0;
    bus.res_ready_i = 1'b1;
    clear_cfg();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_recs(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (recs.size() - base < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_count"}, recs.size() - base, n);
  endtask

  function automatic rec_t get(input int i);
    rec_t r;
    r = '{ch: -1, period: -1, mag: -1, to: -1, ovr: -1, cyc: -1};
    if (base + i < recs.size()) r = recs[base + i];
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rec_t r0, r1, r2, r3, r4;
    int bad, k, rstoff, exp_cyc, d0;

    // Reset state
    bus.res_ready_i = 1'b1;
    clear_cfg();
    step(); step(); step();
    check("rst_valid",   bus.res_valid_o,   0);
    check("rst_done",    done,              0);
    check("rst_ch",      bus.res_ch_o,      0);
    check("rst_period",  bus.res_period_o,  0);
    check("rst_mag",     bus.res_mag_o,     0);
    check("rst_timeout", bus.res_timeout_o, 0);
    check("rst_overrun", bus.res_overrun_o, 0);

    // 1: ch0 square 0/15 period 100
    do_reset();
    mode[0] = 1; hi[0] = 15;
    step(); step(); step();
    base = recs.size();
    d0 = done0_hits;
    enable = 4'b0001;
    wait_recs("t1", 3, 1500);
    r0 = get(0); r1 = get(1); r2 = get(2);
    check("t1_ch",      r0.ch, 0);
    check("t1_period",  r0.period, 100);
    check("t1_mag",     r0.mag, 15);
    check("t1_timeout", r0.to, 0);
    check("t1_overrun", r0.ovr, 0);
    check("t1_period2", r2.period, 100);
    check("t1_gap01",   r1.cyc - r0.cyc, 400);
    check("t1_gap12",   r2.cyc - r1.cyc, 400);
    check("t1_done",    done0_hits - d0, 3);

    // 2: ch1 constant -> timeouts every TO cycles
    do_reset();
    cval[1] = 7;
    step(); step(); step();
    base = recs.size();
    enable = 4'b0010;
    wait_recs("t2", 2, 2300);
    r0 = get(0); r1 = get(1);
    check("t2_ch",      r0.ch, 1);
    check("t2_period",  r0.period, 0);
    check("t2_mag",     r0.mag, 0);
    check("t2_timeout", r0.to, 1);
    check("t2_overrun", r0.ovr, 0);
    check("t2_gap",     r1.cyc - r0.cyc, TO);

    // 3: four channels finish together
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      mode[c] = 1; hi[c] = 15 + 5 * c;
    end
    step(); step(); step();
    base = recs.size();
    enable = 4'b1111;
    wait_recs("t3", 5, 1000);
    for (int i = 0; i < NCH; i++) begin
      r0 = get(i);
      check($sformatf("t3_ch%0d", i),     r0.ch, i);
      check($sformatf("t3_mag%0d", i),    r0.mag, 15 + 5 * i);
      check($sformatf("t3_period%0d", i), r0.period, 100);
    end
    r0 = get(0); r3 = get(3); r4 = get(4);
    check("t3_burst_len", r3.cyc - r0.cyc, 3);
    check("t3_next_ch",   r4.ch, 0);
    check("t3_next_gap",  r4.cyc - r0.cyc, 400);

    // 4: back-pressure, hold and overrun
    do_reset();
    mode[0] = 1; hi[0] = 15;
    bus.res_ready_i = 1'b0;
    step(); step(); step();
    base = recs.size();
    enable = 4'b0001;
    k = 0;
    while (!bus.res_valid_o && k < 700) begin
      step();
      k++;
    end
    check("t4_valid_seen", bus.res_valid_o, 1);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (!(bus.res_valid_o === 1'b1 && bus.res_ch_o === 2'd0 &&
            bus.res_period_o === 16'd100 && bus.res_mag_o === 8'd15 &&
            bus.res_timeout_o === 1'b0 && bus.res_overrun_o === 1'b0)) bad++;
    end
    check("t4_hold_stable", bad, 0);
    bus.res_ready_i = 1'b1;
    wait_recs("t4", 2, 10);
    r0 = get(0); r1 = get(1);
    check("t4_held_ovr",    r0.ovr, 0);
    check("t4_held_period", r0.period, 100);
    check("t4_next_ch",     r1.ch, 0);
    check("t4_next_period", r1.period, 100);
    check("t4_next_ovr",    r1.ovr, 1);
    check("t4_b2b",         r1.cyc - r0.cyc, 1);

    // 5: reset mid-window on ch2
    do_reset();
    mode[2] = 1; hi[2] = 20;
    step(); step(); step();
    base = recs.size();
    enable = 4'b0100;
    wait_recs("t5_pre", 1, 600);
    for (int i = 0; i < 150; i++) step();
    rst = 1'b1;
    step();
    check("t5_rst_valid",  bus.res_valid_o,  0);
    check("t5_rst_done",   done,             0);
    check("t5_rst_period", bus.res_period_o, 0);
    check("t5_rst_mag",    bus.res_mag_o,    0);
    check("t5_rst_ch",     bus.res_ch_o,     0);
    rst = 1'b0;
    rstoff = cyc;
    base = recs.size();
    wait_recs("t5_post", 1, 700);
    exp_cyc = -1;
    foreach (rises[i]) begin
      if (exp_cyc < 0 && rises[i] >= rstoff + 1) exp_cyc = rises[i] + 402;
    end
    r0 = get(0);
    check("t5_first_cyc", r0.cyc, exp_cyc);
    check("t5_ch",        r0.ch, 2);
    check("t5_period",    r0.period, 100);
    check("t5_mag",       r0.mag, 20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
